// File: rtl/ex_mem.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// MEM may stall without a combinational ready path back into EX.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        flush,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [15:0] stall_cnt
);

    localparam logic        RstEnable    = 1'b1;
    localparam logic [4:0]  NOPRegAddr   = 5'd0;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'd0;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam beat_t ZERO_BEAT = '{
        wd:    NOPRegAddr,
        wreg:  WriteDisable,
        wdata: ZeroWord
    };

    state_e      state_q, state_d;
    beat_t       main_q, main_d;
    beat_t       skid_q, skid_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    beat_t in_beat;
    logic  acc;
    logic  pop;

    assign in_beat = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata};

    // Ready depends only on registered state, never on mem_ready.
    assign ex_ready = (state_q != FULL);
    assign acc      = ex_valid & ex_ready;
    assign pop      = valid_q & mem_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = ZERO_BEAT;
            skid_d  = ZERO_BEAT;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_beat;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (acc && pop) begin
                        main_d = in_beat;
                    end else if (acc) begin
                        skid_d  = in_beat;
                        state_d = FULL;
                    end else if (pop) begin
                        main_d  = ZERO_BEAT;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = ZERO_BEAT;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = ZERO_BEAT;
                    skid_d  = ZERO_BEAT;
                end
            endcase
        end
    end

    assign valid_d = (state_d != EMPTY);

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == FULL) && !pop && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= EMPTY;
            main_q  <= ZERO_BEAT;
            skid_q  <= ZERO_BEAT;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wd    = main_q.wd;
    assign mem_wreg  = main_q.wreg;
    assign mem_wdata = main_q.wdata;
    assign mem_valid = valid_q;
    assign stall_cnt = cnt_q;

endmodule
